// File: rtl/addsub_seq.sv
// Chunk-serial adder/subtractor: CHUNK bits per cycle, WIDTH/CHUNK cycles per operation.
// Optional build macro SATURATE_EN clamps signed-overflow results to the signed max/min.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | processing one chunk per cycle, LSB chunk first
// DONE  | result/flags just published, done pulses; start here relaunches immediately
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("addsub_seq: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             op_q;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [CHUNK:0]   csum;
  logic [WIDTH-1:0] sum_next, res_final;
  logic             last, ovf;

  always_comb begin
    a_chunk  = '0;
    b_chunk  = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    csum = {1'b0, a_chunk} + {1'b0, b_chunk ^ {CHUNK{op_q}}} + {{CHUNK{1'b0}}, carry};
    sum_next = sum_q;
    for (int i = 0; i < N; i++) begin
      if (cnt == CW'(i)) sum_next[i*CHUNK +: CHUNK] = csum[CHUNK-1:0];
    end
  end

  assign last = (cnt == CW'(N - 1));
  // Subtract compares A's sign against the sign of the inverted B operand.
  assign ovf  = (a_q[WIDTH-1] == (b_q[WIDTH-1] ^ op_q)) && (sum_next[WIDTH-1] != a_q[WIDTH-1]);

`ifdef SATURATE_EN
  always_comb begin
    res_final = sum_next;
    if (ovf) res_final = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign res_final = sum_next;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      op_q      <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      Result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      negative  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            a_q   <= A;
            b_q   <= B;
            op_q  <= op;
            cnt   <= '0;
            carry <= op;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum_q <= sum_next;
          carry <= csum[CHUNK];
          cnt   <= cnt + 1'b1;
          if (last) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            Result    <= res_final;
            carry_out <= csum[CHUNK];
            overflow  <= ovf;
            zero      <= (res_final == '0);
            negative  <= res_final[WIDTH-1];
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq (WIDTH=32, CHUNK=8): vector table plus abort and back-to-back sequences.
module tb_addsub_seq;

  logic        clock = 1'b0;
  logic        clear, start, op;
  logic [31:0] A, B;
  logic        busy, done, carry_out, overflow, zero, negative;
  logic [31:0] Result;

  int total = 0;
  int bad   = 0;

  addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .Result(Result), .carry_out(carry_out),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic [31:0] a, b, res;
    logic        c, v, z, n;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch from a negedge; during RUN, operand garbage and a stray start are driven.
  // Returns with lat = cycles from the start edge to done (0 if done never came).
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, output int lat);
    logic [31:0] prev;
    prev  = Result;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_after_start", done, 0);
    lat = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc == 2) begin start = 1'b1; op = ~o; A = ~a; B = a; end
      if (cyc == 3) start = 1'b0;
      @(posedge clock); @(negedge clock);
      if (done) begin lat = cyc; break; end
      chk("result_stable_in_run", Result, prev);
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    clear = 1'b1; start = 1'b0; op = 1'b0; A = '0; B = '0;

    vecs[0] = '{1'b1, 32'd20, 32'd10, 32'd10, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef SATURATE_EN
    vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
`else
    vecs[2] = '{1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    vecs[3] = '{1'b1, 32'd100, 32'd100, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_00FF, 32'd1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef SATURATE_EN
    vecs[6] = '{1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    vecs[6] = '{1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif
    vecs[8] = '{1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset values
    @(negedge clock); @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", Result, 0);
    chk("rst_carry", carry_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_zero", zero, 1);
    chk("rst_neg", negative, 0);
    clear = 1'b0;
    @(negedge clock);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, 4);
      chk($sformatf("v%0d_result", i), Result, vecs[i].res);
      chk($sformatf("v%0d_carry", i), carry_out, vecs[i].c);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].v);
      chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
      chk($sformatf("v%0d_neg", i), negative, vecs[i].n);
      @(posedge clock); @(negedge clock);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
    end

    // Abort: start at k, stray start at k+2, clear across k+3
    start = 1'b1; op = 1'b0; A = 32'd5000; B = 32'd1234;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    @(posedge clock); @(negedge clock);
    start = 1'b1; A = 32'd7; B = 32'd9;
    @(posedge clock); @(negedge clock);
    start = 1'b0; clear = 1'b1;
    #1;
    chk("abort_result", Result, 0);
    chk("abort_zero", zero, 1);
    chk("abort_busy", busy, 0);
    chk("abort_carry", carry_out, 0);
    chk("abort_neg", negative, 0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clock); @(negedge clock);
      chk("abort_no_done", done, 0);
    end

    // Start accepted on the first edge after clear falls
    clear = 1'b0; start = 1'b1; op = 1'b0; A = 32'd1; B = 32'd2;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    chk("post_clear_busy", busy, 1);
    for (int c = 0; c < 3; c++) begin @(posedge clock); @(negedge clock); end
    @(posedge clock); @(negedge clock);
    chk("post_clear_done", done, 1);
    chk("post_clear_result", Result, 3);
    @(posedge clock); @(negedge clock);

    // Back-to-back relaunch from DONE
    run_op(1'b1, 32'd2147483647, 32'd123456789, lat);
    chk("b2b_first_latency", lat, 4);
    chk("b2b_first_result", Result, 32'd2024026858);
    chk("b2b_first_carry", carry_out, 1);
    start = 1'b1; op = 1'b1; A = 32'd123456789; B = 32'd98765432;
    @(posedge clock); @(negedge clock);
    start = 1'b0;
    chk("b2b_relaunch_busy", busy, 1);
    chk("b2b_relaunch_done", done, 0);
    chk("b2b_hold_result", Result, 32'd2024026858);
    lat = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clock); @(negedge clock);
      if (done) begin lat = cyc; break; end
    end
    chk("b2b_second_latency", lat, 4);
    chk("b2b_second_result", Result, 32'd24691357);
    chk("b2b_second_carry", carry_out, 1);
    chk("b2b_second_ovf", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits processed per cycle; WIDTH SHALL be a multiple of CHUNK, otherwise elaboration fails; N = WIDTH/CHUNK.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 clear  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; sampled only in IDLE or DONE.
REQ-006 op  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-007 A  input  WIDTH  operand A; sampled with start.
REQ-008 B  input  WIDTH  operand B; sampled with start.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse; Result and flags updated this cycle.
REQ-011 Result  output  WIDTH  last completed result.
REQ-012 carry_out  output  1  carry out of MSB; for subtract, 1 = no borrow.
REQ-013 overflow  output  1  signed overflow of last operation.
REQ-014 zero  output  1  Result == 0.
REQ-015 negative  output  1  Result MSB.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after N chunk cycles; DONE->IDLE after one cycle, or DONE->RUN if start is high.
REQ-017 On start edge: latch A, B, op into working registers; chunk counter = 0; carry = op.
REQ-018 Each RUN edge: chunk i = A[i] + (B[i] XOR {CHUNK{op}}) + carry; store into working sum chunk i; carry <= chunk carry; counter += 1.
REQ-019 Start sampled at edge k -> chunks processed at edges k+1..k+N; done high from edge k+N to edge k+N+1 (latency N cycles after start edge).
REQ-020 On the edge entering DONE: Result, carry_out, overflow, zero, negative SHALL update together; they hold until the next entry into DONE.
REQ-021 Result, carry_out and flags SHALL NOT change during RUN; no partial sums are visible.
REQ-022 overflow: add -> A[MSB]==B[MSB] and sum[MSB]!=A[MSB]; sub -> A[MSB]!=B[MSB] and sum[MSB]!=A[MSB].
REQ-023 start while busy SHALL be ignored; A/B/op changes during RUN SHALL have no effect.
REQ-024 start high in DONE SHALL launch a new operation with no idle cycle; done still pulses for the completing one.
REQ-025 Arithmetic is modulo 2^WIDTH (unless REQ-029 applies); carry_out is the true MSB carry.

Reset
REQ-026 clear high SHALL immediately force IDLE; counter, carry and working registers to 0; busy, done, Result, carry_out, overflow, negative to 0; zero to 1 (consistent with Result=0).
REQ-027 clear during RUN SHALL abort the operation; no done pulse; outputs take reset values.
REQ-028 After clear falls, start SHALL be accepted on the first rising edge.

Configuration
REQ-029 With SATURATE_EN defined: on overflow, Result SHALL clamp to the signed maximum (0111..1) if A[MSB]=0, else to the signed minimum (1000..0); overflow still 1; zero and negative are computed from the clamped value; carry_out remains the raw carry.
REQ-030 Without SATURATE_EN: Result SHALL be the wrapped sum; no clamp logic is present.

Verification (WIDTH=32, CHUNK=8, N=4)
REQ-031 op=1, A=20, B=10, start at edge k -> busy for 4 cycles; done at edge k+4; Result=10, carry_out=1, overflow=0, zero=0.
REQ-032 op=1, A=0, B=1 -> Result=0xFFFFFFFF, carry_out=0, negative=1, overflow=0.
REQ-033 op=0, A=0x7FFFFFFF, B=1 -> overflow=1; Result=0x80000000 without SATURATE_EN, 0x7FFFFFFF with SATURATE_EN.
REQ-034 op=1, A=B=100 -> Result=0, zero=1, carry_out=1.
REQ-035 Start with A=5000, B=1234; pulse start again with new operands at edge k+2; assert clear at edge k+3 -> second start ignored, no done pulse, outputs at reset values.
REQ-036 Back-to-back: start high in the DONE cycle of A=2147483647-123456789 -> first Result=2024026858 with done; second op (A=123456789-98765432) completes 4 edges later with Result=24691357.
